// File: rtl/updi_arb_pkg.sv
// Shared types for the UPDI instruction arbiter: FSM states and the latched
// instruction record handed to the queue handler.
package updi_arb_pkg;

    localparam int UPDI_MAX_DATA_SIZE  = 16;
    localparam int UPDI_DATA_ADDR_BITS = $clog2(UPDI_MAX_DATA_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT_DONE,
        ST_DONE
    } arb_state_e;

    typedef struct packed {
        logic [7:0]                                opcode;
        logic [UPDI_MAX_DATA_SIZE-1:0][7:0]        data;
        logic [UPDI_DATA_ADDR_BITS-1:0]            data_len;
        logic [UPDI_MAX_DATA_SIZE-1:0]             wait_ack_after;
    } updi_instr_t;

endpackage

// File: rtl/updi_rr_pick.sv
// Combinational round-robin picker: finds the first set request after ptr,
// wrapping modulo NUM_REQ.
module updi_rr_pick #(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                valid,
    output logic [IDX_BITS-1:0] idx
);

    logic [IDX_BITS-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_BITS'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/updi_instruction_arbiter.sv
// Round-robin arbiter sharing one UPDI instruction queue handler among NUM_REQ
// requesters: grant, latch, issue with a start pulse, forward ACKs, report done.
module updi_instruction_arbiter
    import updi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MAX_DATA_SIZE  = UPDI_MAX_DATA_SIZE,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int IDX_BITS       = $clog2(NUM_REQ)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ-1:0][7:0]                       req_opcode,
    input  logic [NUM_REQ-1:0][MAX_DATA_SIZE-1:0][7:0]    req_data,
    input  logic [NUM_REQ-1:0][DATA_ADDR_BITS-1:0]        req_data_len,
    input  logic [NUM_REQ-1:0][MAX_DATA_SIZE-1:0]         req_wait_ack,
    output logic [NUM_REQ-1:0]                            gnt,
    output logic [NUM_REQ-1:0]                            done,
    output logic                                          busy,
    input  logic                                          ack_in,
    output logic                                          hq_start,
    input  logic                                          hq_ready,
    input  logic                                          hq_waiting_for_ack,
    output logic                                          hq_ack_received,
    output logic [7:0]                                    hq_opcode,
    output logic [MAX_DATA_SIZE-1:0][7:0]                 hq_data,
    output logic [DATA_ADDR_BITS-1:0]                     hq_data_len,
    output logic [MAX_DATA_SIZE-1:0]                      hq_wait_ack_after
);

    arb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] owner_q, owner_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    updi_instr_t         instr_q, instr_d;

    logic                pick_valid;
    logic [IDX_BITS-1:0] pick_idx;
    logic [NUM_REQ-1:0]  owner_onehot;

    updi_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer resets to the last requester so requester 0 wins the first grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_BITS'(NUM_REQ - 1);
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid && hq_ready) begin
                    owner_d                = pick_idx;
                    ptr_d                  = pick_idx;
                    instr_d.opcode         = req_opcode[pick_idx];
                    instr_d.data           = req_data[pick_idx];
                    instr_d.data_len       = req_data_len[pick_idx];
                    instr_d.wait_ack_after = req_wait_ack[pick_idx];
                    state_d                = ST_ISSUE;
                end
            end
            ST_ISSUE:     state_d = ST_SETTLE;
            // The handler still shows its old ready level here, so it is ignored.
            ST_SETTLE:    state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (hq_ready) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign owner_onehot = NUM_REQ'(1) << owner_q;

    assign busy     = (state_q != ST_IDLE);
    assign gnt      = busy ? owner_onehot : '0;
    assign done     = (state_q == ST_DONE) ? owner_onehot : '0;
    assign hq_start = (state_q == ST_ISSUE);

    assign hq_ack_received = ack_in && hq_waiting_for_ack &&
                             ((state_q == ST_SETTLE) || (state_q == ST_WAIT_DONE));

    assign hq_opcode         = instr_q.opcode;
    assign hq_data           = instr_q.data;
    assign hq_data_len       = instr_q.data_len;
    assign hq_wait_ack_after = instr_q.wait_ack_after;

endmodule

// File: tb/tb_updi_instruction_arbiter.sv
// Directed bench for updi_instruction_arbiter with a small behavioural queue
// handler that writes the transmitted bytes into a FIFO.
module tb_updi_instruction_arbiter;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req;
    logic [1:0][7:0]       req_opcode;
    logic [1:0][15:0][7:0] req_data;
    logic [1:0][3:0]       req_data_len;
    logic [1:0][15:0]      req_wait_ack;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic                  busy;
    logic                  ack_in;
    logic                  hq_start;
    logic                  hq_ready;
    logic                  hq_waiting_for_ack;
    logic                  hq_ack_received;
    logic [7:0]            hq_opcode;
    logic [15:0][7:0]      hq_data;
    logic [3:0]            hq_data_len;
    logic [15:0]           hq_wait_ack_after;

    int total = 0;
    int bad   = 0;

    logic       model_ready;
    logic       model_waiting;
    logic       model_busy;
    logic [3:0] model_idx;
    logic       hold_ready;
    logic [7:0] fifo[$];
    int         start_cnt = 0;
    int         done_cnt0 = 0;
    int         done_cnt1 = 0;

    updi_instruction_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_opcode         (req_opcode),
        .req_data           (req_data),
        .req_data_len       (req_data_len),
        .req_wait_ack       (req_wait_ack),
        .gnt                (gnt),
        .done               (done),
        .busy               (busy),
        .ack_in             (ack_in),
        .hq_start           (hq_start),
        .hq_ready           (hq_ready),
        .hq_waiting_for_ack (hq_waiting_for_ack),
        .hq_ack_received    (hq_ack_received),
        .hq_opcode          (hq_opcode),
        .hq_data            (hq_data),
        .hq_data_len        (hq_data_len),
        .hq_wait_ack_after  (hq_wait_ack_after)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hq_ready           = model_ready && !hold_ready;
    assign hq_waiting_for_ack = model_waiting;

    // Handler model: sync + opcode on start, then one data byte per cycle,
    // stalling for an ACK after every byte whose mask bit is set.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_ready   <= 1'b1;
            model_waiting <= 1'b0;
            model_busy    <= 1'b0;
            model_idx     <= 4'd0;
        end else if (!model_busy) begin
            if (hq_start) begin
                fifo.push_back(8'h55);
                fifo.push_back(hq_opcode);
                model_busy  <= 1'b1;
                model_ready <= 1'b0;
                model_idx   <= 4'd0;
            end
        end else if (model_waiting) begin
            if (hq_ack_received) model_waiting <= 1'b0;
        end else if (model_idx < hq_data_len) begin
            fifo.push_back(hq_data[model_idx]);
            if (hq_wait_ack_after[model_idx]) model_waiting <= 1'b1;
            model_idx <= model_idx + 4'd1;
        end else begin
            model_ready <= 1'b1;
            model_busy  <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (hq_start) start_cnt <= start_cnt + 1;
        if (done[0])  done_cnt0 <= done_cnt0 + 1;
        if (done[1])  done_cnt1 <= done_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input logic [1:0] exp, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === 2'b00 && n < 20);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp));
        check({tag, "_start"}, 32'(hq_start), 32'd1);
    endtask

    task automatic wait_done(input logic [1:0] exp, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === 2'b00 && n < 60);
        check({tag, "_done"}, 32'(done), 32'(exp));
    endtask

    task automatic wait_waiting(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hq_waiting_for_ack !== 1'b1 && n < 30);
        check({tag, "_waiting"}, 32'(hq_waiting_for_ack), 32'd1);
    endtask

    task automatic pulse_ack(input logic exp_fwd, input string tag);
        ack_in = 1'b1;
        #1;
        check({tag, "_fwd"}, 32'(hq_ack_received), 32'(exp_fwd));
        @(negedge clk);
        ack_in = 1'b0;
    endtask

    task automatic check_fifo(input logic [7:0] exp[$], input string tag);
        check({tag, "_len"}, 32'(fifo.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < fifo.size())
                check($sformatf("%s_b%0d", tag, i), 32'(fifo[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int s0;
        int d0;
        int d1;
        rst          = 1'b0;
        req          = 2'b00;
        req_opcode   = '0;
        req_data     = '0;
        req_data_len = '0;
        req_wait_ack = '0;
        ack_in       = 1'b0;
        hold_ready   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt",    32'(gnt),         32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_start",  32'(hq_start),    32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_opcode", 32'(hq_opcode),   32'd0);
        check("rst_len",    32'(hq_data_len), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request from requester 0, zero-length payload
        s0 = start_cnt;
        d0 = done_cnt0;
        req_opcode[0]   = 8'hE5;
        req_data_len[0] = 4'd0;
        req             = 2'b01;
        wait_gnt(2'b01, "t1");
        check("t1_opcode", 32'(hq_opcode), 32'hE5);
        wait_done(2'b01, "t1");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("t1_starts", 32'(start_cnt - s0), 32'd1);
        check("t1_dones",  32'(done_cnt0 - d0), 32'd1);
        check("t1_busy",   32'(busy),           32'd0);
        check_fifo('{8'h55, 8'hE5}, "t1_fifo");

        // Both requesting continuously: strict alternation starting at 1
        fifo.delete();
        req_opcode[0] = 8'h10;
        req_opcode[1] = 8'h11;
        req           = 2'b11;
        wait_gnt(2'b10, "t2a");
        wait_done(2'b10, "t2a");
        wait_gnt(2'b01, "t2b");
        wait_done(2'b01, "t2b");
        wait_gnt(2'b10, "t2c");
        wait_done(2'b10, "t2c");
        wait_gnt(2'b01, "t2d");
        wait_done(2'b01, "t2d");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check_fifo('{8'h55, 8'h11, 8'h55, 8'h10, 8'h55, 8'h11, 8'h55, 8'h10}, "t2_fifo");

        // Four data bytes with ACK stalls after bytes 1 and 3
        fifo.delete();
        d1 = done_cnt1;
        req_opcode[1]   = 8'h45;
        req_data[1][0]  = 8'h12;
        req_data[1][1]  = 8'h34;
        req_data[1][2]  = 8'h56;
        req_data[1][3]  = 8'h78;
        req_data_len[1] = 4'd4;
        req_wait_ack[1] = 16'h000A;
        req             = 2'b10;
        wait_gnt(2'b10, "t3");
        @(negedge clk);
        pulse_ack(1'b0, "t3_early");
        wait_waiting("t3_ack1");
        pulse_ack(1'b1, "t3_ack1");
        check("t3_busy_mid",  32'(busy),             32'd1);
        check("t3_no_done",   32'(done_cnt1 - d1),   32'd0);
        wait_waiting("t3_ack2");
        pulse_ack(1'b1, "t3_ack2");
        wait_done(2'b10, "t3");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("t3_dones", 32'(done_cnt1 - d1), 32'd1);
        check_fifo('{8'h55, 8'h45, 8'h12, 8'h34, 8'h56, 8'h78}, "t3_fifo");

        // Payload altered after grant must not reach the handler
        fifo.delete();
        req_opcode[0]   = 8'hA1;
        req_data[0][0]  = 8'h9A;
        req_data[0][1]  = 8'hBC;
        req_data_len[0] = 4'd2;
        req_wait_ack[0] = 16'h0000;
        req             = 2'b01;
        wait_gnt(2'b01, "t4");
        req_opcode[0]   = 8'h00;
        req_data[0][0]  = 8'hFF;
        req_data[0][1]  = 8'hFF;
        req_data_len[0] = 4'd1;
        wait_done(2'b01, "t4");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check_fifo('{8'h55, 8'hA1, 8'h9A, 8'hBC}, "t4_fifo");

        // Asynchronous reset while stalled in WAIT_DONE
        req_opcode[1]   = 8'h66;
        req_data_len[1] = 4'd2;
        req_wait_ack[1] = 16'h0001;
        req             = 2'b10;
        wait_gnt(2'b10, "t5");
        wait_waiting("t5");
        rst = 1'b0;
        #1;
        check("t5_gnt",    32'(gnt),               32'd0);
        check("t5_busy",   32'(busy),              32'd0);
        check("t5_start",  32'(hq_start),          32'd0);
        check("t5_done",   32'(done),              32'd0);
        check("t5_opcode", 32'(hq_opcode),         32'd0);
        check("t5_len",    32'(hq_data_len),       32'd0);
        check("t5_mask",   32'(hq_wait_ack_after), 32'd0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        fifo.delete();
        req_opcode[1]   = 8'h77;
        req_data_len[1] = 4'd0;
        req_wait_ack[1] = 16'h0000;
        req             = 2'b10;
        wait_gnt(2'b10, "t5r");
        wait_done(2'b10, "t5r");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check_fifo('{8'h55, 8'h77}, "t5_fifo");

        // Handler not ready in IDLE: requests must wait
        s0 = start_cnt;
        hold_ready      = 1'b1;
        req_opcode[0]   = 8'h88;
        req_data_len[0] = 4'd0;
        req             = 2'b01;
        repeat (4) @(negedge clk);
        check("t6_hold_gnt",   32'(gnt),             32'd0);
        check("t6_hold_busy",  32'(busy),            32'd0);
        check("t6_hold_start", 32'(start_cnt - s0),  32'd0);
        hold_ready = 1'b0;
        @(negedge clk);
        check("t6_gnt",   32'(gnt),      32'd1);
        check("t6_start", 32'(hq_start), 32'd1);
        wait_done(2'b01, "t6");
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("t6_starts", 32'(start_cnt - s0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
